// File: rtl/seg_split.sv
// seg_split: splits a clipped signed modulator code into a coarse count
// (18-element segment, weight 4) and a fine count (6-element segment,
// weight 1) with 4*VB + VC = code. The ambiguous middle residue alternates
// between the two legal splits to balance element usage. Alongside, a small
// FSM flags sustained overload and a counter tallies saturated samples.
// Two register stages: stage 1 clips, stage 2 splits and drives the outputs.
module seg_split (
  input  logic              clk,
  input  logic              rstn,
  input  logic signed [7:0] D_IN,
  input  logic              D_VLD,
  input  logic              SEG_SEL,
  output logic signed [5:0] VB,
  output logic signed [3:0] VC,
  output logic              VOUT_VLD,
  output logic              OVL,
  output logic [7:0]        SAT_CNT
);

  localparam logic signed [7:0] CLIP_POS = 8'sd74;
  localparam logic signed [7:0] CLIP_NEG = -8'sd74;

  typedef enum logic [1:0] {
    ST_NRM,
    ST_SATP,
    ST_OVL,
    ST_RECV
  } ovl_state_t;

  // ---------------------------------------------------------------- stage 1
  logic signed [7:0] dc_clip;
  logic              sat_clip;

  logic              v1;
  logic signed [7:0] dc1;
  logic              sat1;
  logic              seg1;

  // Clip the incoming code to the representable range and flag saturation.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    dc_clip  = D_IN;
    sat_clip = 1'b0;
    if (D_IN > CLIP_POS) begin
      dc_clip  = CLIP_POS;
      sat_clip = 1'b1;
    end else if (D_IN < CLIP_NEG) begin
      dc_clip  = CLIP_NEG;
      sat_clip = 1'b1;
    end
  end

  // Stage-1 register. SEG_SEL travels with the sample so a change of the
  // balancing mode applies from the sample it was presented with onward.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      dc1  <= '0;
      sat1 <= 1'b0;
      seg1 <= 1'b0;
    end else begin
      v1   <= D_VLD;
      seg1 <= SEG_SEL;
      if (D_VLD) begin
        dc1  <= dc_clip;
        sat1 <= sat_clip;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic              t;
  logic              t_eff;
  logic signed [7:0] base;
  logic signed [7:0] base_p1;
  logic [1:0]        r;
  logic              forced_pos;
  logic              forced_neg;
  logic              toggle;
  logic signed [5:0] vb_next;
  logic signed [3:0] vc_next;

  // Split: base = floor(dc/4) via arithmetic shift, residue from low bits.
  // At +/-74 only one split fits the segment ranges, so T is ignored there.
  always_comb begin
    base       = dc1 >>> 2;
    base_p1    = base + 8'sd1;
    r          = dc1[1:0];
    forced_pos = (dc1 == CLIP_POS);
    forced_neg = (dc1 == CLIP_NEG);
    t_eff      = t & ~seg1;
    toggle     = 1'b0;
    vb_next    = base[5:0];
    vc_next    = 4'sd0;
    case (r)
      2'd0: begin
        vb_next = base[5:0];
        vc_next = 4'sd0;
      end
      2'd1: begin
        vb_next = base[5:0];
        vc_next = 4'sd1;
      end
      2'd3: begin
        vb_next = base_p1[5:0];
        vc_next = -4'sd1;
      end
      default: begin
        if (forced_pos) begin
          vb_next = base[5:0];
          vc_next = 4'sd2;
        end else if (forced_neg) begin
          vb_next = base_p1[5:0];
          vc_next = -4'sd2;
        end else begin
          toggle = 1'b1;
          if (t_eff) begin
            vb_next = base_p1[5:0];
            vc_next = -4'sd2;
          end else begin
            vb_next = base[5:0];
            vc_next = 4'sd2;
          end
        end
      end
    endcase
  end

  // Balancing toggle: held at 0 while balancing is disabled, otherwise flips
  // after each unforced middle-residue sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t <= 1'b0;
    end else if (seg1) begin
      t <= 1'b0;
    end else if (v1 && toggle) begin
      t <= ~t;
    end
  end

  // Output register: new split on a valid stage-1 sample, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      VB       <= '0;
      VC       <= '0;
      VOUT_VLD <= 1'b0;
      SAT_CNT  <= '0;
    end else begin
      VOUT_VLD <= v1;
      if (v1) begin
        VB <= vb_next;
        VC <= vc_next;
        if (sat1 && (SAT_CNT != 8'hFF)) begin
          SAT_CNT <= SAT_CNT + 8'd1;
        end
      end
    end
  end

  // ------------------------------------------------------------ overload FSM
  ovl_state_t state, state_n;
  logic [2:0] run, run_n;
  logic [4:0] clr, clr_n;

  // State, run-length and recovery counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_NRM;
      run   <= '0;
      clr   <= '0;
      OVL   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= run_n;
      clr   <= clr_n;
      OVL   <= (state_n == ST_OVL) || (state_n == ST_RECV);
    end
  end

  // Next-state logic; advances only on valid stage-1 samples so OVL lands
  // on the same edge as the split of the sample that caused the change.
  always_comb begin
    state_n = state;
    run_n   = run;
    clr_n   = clr;
    if (v1) begin
      case (state)
        ST_NRM: begin
          if (sat1) begin
            state_n = ST_SATP;
            run_n   = 3'd1;
          end
        end
        ST_SATP: begin
          if (!sat1) begin
            state_n = ST_NRM;
            run_n   = 3'd0;
          end else if (run == 3'd3) begin
            state_n = ST_OVL;
            run_n   = 3'd0;
          end else begin
            run_n = run + 3'd1;
          end
        end
        ST_OVL: begin
          if (!sat1) begin
            state_n = ST_RECV;
            clr_n   = 5'd1;
          end
        end
        default: begin
          if (sat1) begin
            state_n = ST_OVL;
            clr_n   = 5'd0;
          end else if (clr == 5'd15) begin
            state_n = ST_NRM;
            clr_n   = 5'd0;
          end else begin
            clr_n = clr + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_split.sv
// Testbench for seg_split: table of hand-derived splits fed through a
// scoreboard queue, plus sequences for overload, counter saturation,
// latency and mid-stream reset.
module tb_seg_split;

  logic              clk;
  logic              rstn;
  logic signed [7:0] D_IN;
  logic              D_VLD;
  logic              SEG_SEL;
  logic signed [5:0] VB;
  logic signed [3:0] VC;
  logic              VOUT_VLD;
  logic              OVL;
  logic [7:0]        SAT_CNT;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int vb;
    int vc;
    int ovl;
    int sc;
  } exp_t;

  typedef struct {
    logic signed [7:0] d;
    logic              seg;
    int                vb;
    int                vc;
    int                sc;
  } vec_t;

  exp_t exp_q[$];
  int   last_vb = 0;
  int   last_vc = 0;

  seg_split dut (
    .clk     (clk),
    .rstn    (rstn),
    .D_IN    (D_IN),
    .D_VLD   (D_VLD),
    .SEG_SEL (SEG_SEL),
    .VB      (VB),
    .VC      (VC),
    .VOUT_VLD(VOUT_VLD),
    .OVL     (OVL),
    .SAT_CNT (SAT_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on every valid output, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      last_vb = 0;
      last_vc = 0;
    end else if (VOUT_VLD) begin
      if (exp_q.size() == 0) begin
        check("vld_without_sample", int'(VOUT_VLD), 0);
      end else begin
        e = exp_q.pop_front();
        check("vb", int'(VB), e.vb);
        check("vc", int'(VC), e.vc);
        check("ovl", int'(OVL), e.ovl);
        check("sat_cnt", int'(SAT_CNT), e.sc);
        last_vb = e.vb;
        last_vc = e.vc;
      end
    end else begin
      check("hold_vb", int'(VB), last_vb);
      check("hold_vc", int'(VC), last_vc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] d, input logic seg,
                       input int vb, input int vc, input int ovl, input int sc);
    exp_t e;
    e.vb = vb; e.vc = vc; e.ovl = ovl; e.sc = sc;
    D_IN    = d;
    SEG_SEL = seg;
    D_VLD   = 1'b1;
    exp_q.push_back(e);
    step();
    D_VLD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("drain_queue_left", exp_q.size(), 0);
  endtask

  vec_t vecs[$];

  initial begin
    // {d_in, seg_sel, vb, vc, sat_cnt}; T starts at 0 after reset
    vecs = '{
      '{ 8'sd6,    1'b0,   1,  2, 0},
      '{ 8'sd6,    1'b0,   2, -2, 0},
      '{ 8'sd6,    1'b0,   1,  2, 0},
      '{ 8'sd6,    1'b0,   2, -2, 0},
      '{ 8'sd6,    1'b1,   1,  2, 0},
      '{ 8'sd6,    1'b1,   1,  2, 0},
      '{ 8'sd6,    1'b1,   1,  2, 0},
      '{ 8'sd6,    1'b1,   1,  2, 0},
      '{ 8'sd10,   1'b0,   2,  2, 0},
      '{ 8'sd11,   1'b0,   3, -1, 0},
      '{ 8'sd9,    1'b0,   2,  1, 0},
      '{ 8'sd12,   1'b0,   3,  0, 0},
      '{ 8'sd127,  1'b0,  18,  2, 1},
      '{-8'sd128,  1'b0, -18, -2, 2},
      '{-8'sd73,   1'b0, -18, -1, 2},
      '{ 8'sd6,    1'b0,   2, -2, 2},
      '{ 8'sd74,   1'b0,  18,  2, 2},
      '{-8'sd74,   1'b0, -18, -2, 2},
      '{ 8'sd6,    1'b0,   1,  2, 2},
      '{ 8'sd75,   1'b0,  18,  2, 3},
      '{-8'sd1,    1'b0,   0, -1, 3},
      '{-8'sd2,    1'b0,   0, -2, 3},
      '{ 8'sd0,    1'b0,   0,  0, 3},
      '{-8'sd5,    1'b0,  -1, -1, 3},
      '{ 8'sd5,    1'b0,   1,  1, 3}
    };

    rstn    = 1'b1;
    D_IN    = '0;
    D_VLD   = 1'b0;
    SEG_SEL = 1'b0;
    #1 rstn = 1'b0;
    #2;
    check("rst_vb", int'(VB), 0);
    check("rst_vc", int'(VC), 0);
    check("rst_vld", int'(VOUT_VLD), 0);
    check("rst_ovl", int'(OVL), 0);
    check("rst_sat_cnt", int'(SAT_CNT), 0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // Table, with a one-cycle gap after every fourth sample
    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].seg, vecs[i].vb, vecs[i].vc, 0, vecs[i].sc);
      if (i % 4 == 3) idle(1);
    end
    drain();

    // Sustained overload: OVL rises with the 4th saturated output,
    // falls with the 16th clean output.
    for (int i = 0; i < 5; i++) drive(8'sd100, 1'b0, 18, 2, (i >= 3) ? 1 : 0, 4 + i);
    for (int i = 0; i < 16; i++) drive(8'sd0, 1'b0, 0, 0, (i < 15) ? 1 : 0, 8);
    drain();

    // Saturated-sample counter stops at 255
    for (int i = 0; i < 300; i++) begin
      drive(-8'sd128, 1'b0, -18, -2, (i >= 3) ? 1 : 0,
            (9 + i > 255) ? 255 : 9 + i);
    end
    drain();
    idle(3);
    check("sat_cnt_held", int'(SAT_CNT), 255);
    check("ovl_held", int'(OVL), 1);

    // Mid-stream reset: in-flight sample is discarded, outputs clear at once
    D_IN  = -8'sd128;
    D_VLD = 1'b1;
    step();
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_vb", int'(VB), 0);
    check("mid_rst_vc", int'(VC), 0);
    check("mid_rst_vld", int'(VOUT_VLD), 0);
    check("mid_rst_ovl", int'(OVL), 0);
    check("mid_rst_sat_cnt", int'(SAT_CNT), 0);
    D_VLD = 1'b0;
    step();
    #2 rstn = 1'b1;
    idle(4);

    // First output after release follows a new D_VLD by two cycles
    begin
      exp_t e;
      e.vb = 2; e.vc = 1; e.ovl = 0; e.sc = 0;
      D_IN  = 8'sd9;
      D_VLD = 1'b1;
      exp_q.push_back(e);
      step();
      D_VLD = 1'b0;
      check("latency_cycle1_vld", int'(VOUT_VLD), 0);
      step();
      check("latency_cycle2_vld", int'(VOUT_VLD), 1);
    end
    drain();

    // Toggle restarts from 0 after reset
    drive(8'sd6, 1'b0, 1, 2, 0, 0);
    drive(-8'sd2, 1'b0, 0, -2, 0, 0);
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
